pu_msp430_mpy_arbiter: RTL and testbench

Two-master arbiter sharing the single hardware-multiplier peripheral between requester 0 (CPU peripheral bus) and requester 1 (DMA or debug bus master). It decodes the multiplier register window and grants one requester at a time. It locks ownership across a full multiply sequence, from the OP1 write to the final result read, so the other master cannot corrupt the operands or the accumulator. It sits between the two bus masters and the multiplier's per_* port and adds no latency to the granted access.

---
 rtl/pu_msp430_mpy_arb_pkg.sv | 34 +++
 rtl/pu_msp430_mpy_arb_timer.sv | 41 ++++
 rtl/pu_msp430_mpy_arbiter.sv | 145 ++++++++++++++
 tb/tb_pu_msp430_mpy_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_msp430_mpy_arb_pkg.sv
// Shared types and constants for the hardware-multiplier arbiter.
package pu_msp430_mpy_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Width of the owner idle counter.
  localparam int CNT_W = 8;

  // Byte offsets of the multiplier registers inside the decoded window.
  localparam logic [3:0] OFS_OP1_MPY  = 4'h0;
  localparam logic [3:0] OFS_OP1_MPYS = 4'h2;
  localparam logic [3:0] OFS_OP1_MAC  = 4'h4;
  localparam logic [3:0] OFS_OP1_MACS = 4'h6;
  localparam logic [3:0] OFS_OP2      = 4'h8;
  localparam logic [3:0] OFS_RESLO    = 4'hA;
  localparam logic [3:0] OFS_RESHI    = 4'hC;
  localparam logic [3:0] OFS_SUMEXT   = 4'hE;

  // A write to any OP1 register starts (or continues) a multiply sequence.
  function automatic logic is_op1(input logic [3:0] ofs);
    return (ofs == OFS_OP1_MPY) || (ofs == OFS_OP1_MPYS) ||
           (ofs == OFS_OP1_MAC) || (ofs == OFS_OP1_MACS);
  endfunction

  // A read of RESHI or SUMEXT is the last access of a sequence.
  function automatic logic is_release(input logic [3:0] ofs);
    return (ofs == OFS_RESHI) || (ofs == OFS_SUMEXT);
  endfunction

endpackage

// File: rtl/pu_msp430_mpy_arb_timer.sv
// Owner idle counter: counts cycles the lock owner leaves the multiplier
// untouched and flags the terminal count LOCK_TO-1.
module pu_msp430_mpy_arb_timer
  import pu_msp430_mpy_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] LOCK_TO = 8'd32
) (
  input  logic mclk,
  input  logic puc_rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == (LOCK_TO - CNT_W'(1)));

  // Next count: clear wins, otherwise count up until terminal count.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge mclk) begin
    // NOTE: non-blocking assignment keeps all flops updating on the same edge.
    if (puc_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pu_msp430_mpy_arbiter.sv
// Two-master arbiter for the hardware multiplier. Grants one requester per
// cycle with zero added latency and locks ownership from an OP1 write until
// the closing RESHI/SUMEXT read or an idle timeout.
module pu_msp430_mpy_arbiter
  import pu_msp430_mpy_arb_pkg::*;
#(
  parameter logic [14:0]      BASE_ADDR = 15'h0130,
  parameter int               DEC_WD    = 4,
  parameter logic [CNT_W-1:0] LOCK_TO   = 8'd32
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        r0_per_en,
  input  logic [13:0] r0_per_addr,
  input  logic [15:0] r0_per_din,
  input  logic [1:0]  r0_per_we,
  output logic [15:0] r0_per_dout,
  output logic        r0_wait,
  input  logic        r1_per_en,
  input  logic [13:0] r1_per_addr,
  input  logic [15:0] r1_per_din,
  input  logic [1:0]  r1_per_we,
  output logic [15:0] r1_per_dout,
  output logic        r1_wait,
  output logic        mpy_per_en,
  output logic [13:0] mpy_per_addr,
  output logic [15:0] mpy_per_din,
  output logic [1:0]  mpy_per_we,
  input  logic [15:0] mpy_per_dout,
  output logic [1:0]  owner,
  output logic        lock_to_evt
);

  arb_state_e state_q, state_d;
  logic       prio_q, prio_d;
  logic       lock_to_evt_q, lock_to_evt_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic [3:0] ofs0, ofs1, g_ofs;
  logic       g_wr;
  logic       own_req;
  logic       tmr_clear, tmr_en, tmr_tc;

  // Window decode and local byte offset per requester.
  assign req[0] = r0_per_en & (r0_per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign req[1] = r1_per_en & (r1_per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign ofs0   = 4'({r0_per_addr[DEC_WD-2:0], 1'b0});
  assign ofs1   = 4'({r1_per_addr[DEC_WD-2:0], 1'b0});

  // Grant: priority bit in IDLE, owner only while locked, nothing in reset.
  always_comb begin
    grant = 2'b00;
    if (!puc_rst) begin
      case (state_q)
        IDLE:    grant = (&req) ? (prio_q ? 2'b10 : 2'b01) : req;
        OWN0:    grant = {1'b0, req[0]};
        OWN1:    grant = {req[1], 1'b0};
        default: grant = 2'b00;
      endcase
    end
  end

  assign g_ofs   = grant[1] ? ofs1 : ofs0;
  assign g_wr    = grant[1] ? (|r1_per_we) : (|r0_per_we);
  assign own_req = ((state_q == OWN0) & req[0]) | ((state_q == OWN1) & req[1]);
  assign r0_wait = req[0] & ~grant[0];
  assign r1_wait = req[1] & ~grant[1];

  // Next state, priority and timeout pulse.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    lock_to_evt_d = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the loser gets priority next time.
        if (&req) prio_d = grant[0];
        if ((|grant) && g_wr && is_op1(g_ofs)) state_d = grant[1] ? OWN1 : OWN0;
      end
      OWN0, OWN1: begin
        if ((|grant) && !g_wr && is_release(g_ofs)) begin
          state_d = IDLE;
        end else if (!own_req && tmr_tc) begin
          state_d       = IDLE;
          lock_to_evt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, priority and event registers.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      lock_to_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      lock_to_evt_q <= lock_to_evt_d;
    end
  end

  assign owner       = {state_q == OWN1, state_q == OWN0};
  assign lock_to_evt = lock_to_evt_q;

  // Counter stays at zero in IDLE and restarts on every owner access.
  assign tmr_clear = (state_q == IDLE) | (state_d == IDLE) | own_req;
  assign tmr_en    = (state_q != IDLE);

  pu_msp430_mpy_arb_timer #(
    .LOCK_TO (LOCK_TO)
  ) u_timer (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .tc      (tmr_tc)
  );

  // Route the granted requester to the multiplier, zeros otherwise.
  always_comb begin
    mpy_per_en   = 1'b0;
    mpy_per_addr = '0;
    mpy_per_din  = '0;
    mpy_per_we   = '0;
    if (grant[0]) begin
      mpy_per_en   = 1'b1;
      mpy_per_addr = r0_per_addr;
      mpy_per_din  = r0_per_din;
      mpy_per_we   = r0_per_we;
    end else if (grant[1]) begin
      mpy_per_en   = 1'b1;
      mpy_per_addr = r1_per_addr;
      mpy_per_din  = r1_per_din;
      mpy_per_we   = r1_per_we;
    end
  end

  assign r0_per_dout = grant[0] ? mpy_per_dout : 16'h0000;
  assign r1_per_dout = grant[1] ? mpy_per_dout : 16'h0000;

endmodule

// File: tb/tb_pu_msp430_mpy_arbiter.sv
// Directed bench for the multiplier arbiter: inputs change 1 ns after the
// rising edge and outputs are sampled 1 ns later, away from the edge.
module tb_pu_msp430_mpy_arbiter;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        r0_per_en,  r1_per_en;
  logic [13:0] r0_per_addr, r1_per_addr;
  logic [15:0] r0_per_din,  r1_per_din;
  logic [1:0]  r0_per_we,   r1_per_we;
  logic [15:0] r0_per_dout, r1_per_dout;
  logic        r0_wait,     r1_wait;
  logic        mpy_per_en;
  logic [13:0] mpy_per_addr;
  logic [15:0] mpy_per_din;
  logic [1:0]  mpy_per_we;
  logic [15:0] mpy_per_dout;
  logic [1:0]  owner;
  logic        lock_to_evt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 mclk = ~mclk;

  pu_msp430_mpy_arbiter #(
    .BASE_ADDR (15'h0130),
    .DEC_WD    (4),
    .LOCK_TO   (8'd32)
  ) dut (
    .mclk         (mclk),
    .puc_rst      (puc_rst),
    .r0_per_en    (r0_per_en),
    .r0_per_addr  (r0_per_addr),
    .r0_per_din   (r0_per_din),
    .r0_per_we    (r0_per_we),
    .r0_per_dout  (r0_per_dout),
    .r0_wait      (r0_wait),
    .r1_per_en    (r1_per_en),
    .r1_per_addr  (r1_per_addr),
    .r1_per_din   (r1_per_din),
    .r1_per_we    (r1_per_we),
    .r1_per_dout  (r1_per_dout),
    .r1_wait      (r1_wait),
    .mpy_per_en   (mpy_per_en),
    .mpy_per_addr (mpy_per_addr),
    .mpy_per_din  (mpy_per_din),
    .mpy_per_we   (mpy_per_we),
    .mpy_per_dout (mpy_per_dout),
    .owner        (owner),
    .lock_to_evt  (lock_to_evt)
  );

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic drive0(input logic en, input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
    r0_per_en = en; r0_per_addr = a; r0_per_din = d; r0_per_we = we;
  endtask

  task automatic drive1(input logic en, input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
    r1_per_en = en; r1_per_addr = a; r1_per_din = d; r1_per_we = we;
  endtask

  task automatic idle_all;
    drive0(1'b0, 14'h0, 16'h0, 2'b00);
    drive1(1'b0, 14'h0, 16'h0, 2'b00);
  endtask

  task automatic test_reset;
    drive0(1'b1, 14'h009D, 16'h0000, 2'b00);
    drive1(1'b1, 14'h0050, 16'h5555, 2'b11);
    mpy_per_dout = 16'hBEEF;
    #1;
    vectors++; if (mpy_per_en !== 1'b0) begin miscompares++; $display("FAIL reset_mpy_en: got %b want 0", mpy_per_en); end
    vectors++; if (r0_wait !== 1'b1) begin miscompares++; $display("FAIL reset_r0_wait: got %b want 1", r0_wait); end
    vectors++; if (r1_wait !== 1'b0) begin miscompares++; $display("FAIL reset_r1_wait_nonwindow: got %b want 0", r1_wait); end
    vectors++; if (r0_per_dout !== 16'h0000) begin miscompares++; $display("FAIL reset_r0_dout: got %h want 0000", r0_per_dout); end
    vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL reset_owner: got %b want 00", owner); end
    vectors++; if (lock_to_evt !== 1'b0) begin miscompares++; $display("FAIL reset_evt: got %b want 0", lock_to_evt); end
    puc_rst = 1'b0;
    #1;
    vectors++; if (r0_wait !== 1'b0) begin miscompares++; $display("FAIL postrst_r0_wait: got %b want 0", r0_wait); end
    vectors++; if (r0_per_dout !== 16'hBEEF) begin miscompares++; $display("FAIL postrst_r0_dout: got %h want beef", r0_per_dout); end
    vectors++; if (r1_per_dout !== 16'h0000) begin miscompares++; $display("FAIL nonwindow_r1_dout: got %h want 0000", r1_per_dout); end
    idle_all;
    tick;
  endtask

  task automatic test_simultaneous;
    drive0(1'b1, 14'h009D, 16'h1111, 2'b00);
    drive1(1'b1, 14'h009D, 16'h2222, 2'b00);
    #1;
    vectors++; if (r0_wait !== 1'b0) begin miscompares++; $display("FAIL sim1_r0_wait: got %b want 0", r0_wait); end
    vectors++; if (r1_wait !== 1'b1) begin miscompares++; $display("FAIL sim1_r1_wait: got %b want 1", r1_wait); end
    vectors++; if (mpy_per_din !== 16'h1111) begin miscompares++; $display("FAIL sim1_din: got %h want 1111", mpy_per_din); end
    tick;
    drive0(1'b0, 14'h0, 16'h0, 2'b00);
    #1;
    vectors++; if (r1_wait !== 1'b0) begin miscompares++; $display("FAIL sim1_r1_next: got %b want 0", r1_wait); end
    vectors++; if (mpy_per_din !== 16'h2222) begin miscompares++; $display("FAIL sim1_din_next: got %h want 2222", mpy_per_din); end
    tick;
    drive0(1'b1, 14'h009D, 16'h1111, 2'b00);
    #1;
    vectors++; if (r1_wait !== 1'b0) begin miscompares++; $display("FAIL sim2_r1_wait: got %b want 0", r1_wait); end
    vectors++; if (r0_wait !== 1'b1) begin miscompares++; $display("FAIL sim2_r0_wait: got %b want 1", r0_wait); end
    vectors++; if (mpy_per_din !== 16'h2222) begin miscompares++; $display("FAIL sim2_din: got %h want 2222", mpy_per_din); end
    tick;
    drive1(1'b0, 14'h0, 16'h0, 2'b00);
    #1;
    vectors++; if (r0_wait !== 1'b0) begin miscompares++; $display("FAIL sim2_r0_next: got %b want 0", r0_wait); end
    vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL sim_owner: got %b want 00", owner); end
    idle_all;
    tick;
  endtask

  task automatic test_unlocked_read;
    drive0(1'b1, 14'h009D, 16'h0000, 2'b00);
    mpy_per_dout = 16'h1234;
    #1;
    vectors++; if (mpy_per_en !== 1'b1) begin miscompares++; $display("FAIL ur_mpy_en: got %b want 1", mpy_per_en); end
    vectors++; if (mpy_per_addr !== 14'h009D) begin miscompares++; $display("FAIL ur_addr: got %h want 009d", mpy_per_addr); end
    vectors++; if (r0_per_dout !== 16'h1234) begin miscompares++; $display("FAIL ur_r0_dout: got %h want 1234", r0_per_dout); end
    vectors++; if (r1_per_dout !== 16'h0000) begin miscompares++; $display("FAIL ur_r1_dout: got %h want 0000", r1_per_dout); end
    tick;
    idle_all;
    #1;
    vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL ur_owner: got %b want 00", owner); end
    vectors++; if (mpy_per_en !== 1'b0) begin miscompares++; $display("FAIL ur_idle_en: got %b want 0", mpy_per_en); end
    tick;
  endtask

  task automatic test_lock_release;
    drive0(1'b1, 14'h0098, 16'h0012, 2'b11);
    #1;
    vectors++; if (mpy_per_din !== 16'h0012 || mpy_per_we !== 2'b11) begin miscompares++; $display("FAIL lr_op1: got din %h we %b want 0012 11", mpy_per_din, mpy_per_we); end
    tick;
    drive0(1'b0, 14'h0, 16'h0, 2'b00);
    drive1(1'b1, 14'h009C, 16'h0034, 2'b11);
    #1;
    vectors++; if (owner !== 2'b01) begin miscompares++; $display("FAIL lr_owner: got %b want 01", owner); end
    vectors++; if (r1_wait !== 1'b1) begin miscompares++; $display("FAIL lr_r1_wait: got %b want 1", r1_wait); end
    vectors++; if (mpy_per_en !== 1'b0) begin miscompares++; $display("FAIL lr_mpy_en: got %b want 0", mpy_per_en); end
    tick;
    vectors++; if (r1_wait !== 1'b1) begin miscompares++; $display("FAIL lr_r1_wait2: got %b want 1", r1_wait); end
    drive0(1'b1, 14'h009E, 16'h0000, 2'b00);
    mpy_per_dout = 16'h00AB;
    #1;
    vectors++; if (r0_wait !== 1'b0 || mpy_per_addr !== 14'h009E) begin miscompares++; $display("FAIL lr_reshi: got wait %b addr %h want 0 009e", r0_wait, mpy_per_addr); end
    vectors++; if (r0_per_dout !== 16'h00AB) begin miscompares++; $display("FAIL lr_reshi_dout: got %h want 00ab", r0_per_dout); end
    vectors++; if (r1_wait !== 1'b1) begin miscompares++; $display("FAIL lr_r1_wait3: got %b want 1", r1_wait); end
    tick;
    drive0(1'b0, 14'h0, 16'h0, 2'b00);
    #1;
    vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL lr_released: got %b want 00", owner); end
    vectors++; if (r1_wait !== 1'b0 || mpy_per_din !== 16'h0034) begin miscompares++; $display("FAIL lr_r1_grant: got wait %b din %h want 0 0034", r1_wait, mpy_per_din); end
    idle_all;
    tick;
  endtask

  task automatic test_timeout;
    drive1(1'b1, 14'h009A, 16'h00AB, 2'b01);
    #1;
    vectors++; if (mpy_per_we !== 2'b01) begin miscompares++; $display("FAIL to_we: got %b want 01", mpy_per_we); end
    tick;
    drive1(1'b0, 14'h0, 16'h0, 2'b00);
    drive0(1'b1, 14'h0098, 16'h0000, 2'b00);
    #1;
    vectors++; if (owner !== 2'b10) begin miscompares++; $display("FAIL to_owner: got %b want 10", owner); end
    for (int i = 1; i <= 31; i++) begin
      tick;
      vectors++; if (lock_to_evt !== 1'b0 || r0_wait !== 1'b1) begin miscompares++; $display("FAIL to_early_c%0d: got evt %b wait %b want 0 1", i, lock_to_evt, r0_wait); end
    end
    tick;
    vectors++; if (lock_to_evt !== 1'b1) begin miscompares++; $display("FAIL to_evt_c32: got %b want 1", lock_to_evt); end
    vectors++; if (owner !== 2'b00 || r0_wait !== 1'b0) begin miscompares++; $display("FAIL to_release: got owner %b wait %b want 00 0", owner, r0_wait); end
    idle_all;
    tick;
    vectors++; if (lock_to_evt !== 1'b0) begin miscompares++; $display("FAIL to_evt_width: got %b want 0", lock_to_evt); end
  endtask

  task automatic test_timeout_vs_request;
    drive1(1'b1, 14'h0098, 16'h0003, 2'b11);
    tick;
    drive1(1'b0, 14'h0, 16'h0, 2'b00);
    repeat (31) tick;
    drive1(1'b1, 14'h009D, 16'h0000, 2'b00);
    #1;
    vectors++; if (r1_wait !== 1'b0) begin miscompares++; $display("FAIL tvr_grant: got wait %b want 0", r1_wait); end
    tick;
    drive1(1'b0, 14'h0, 16'h0, 2'b00);
    #1;
    vectors++; if (owner !== 2'b10 || lock_to_evt !== 1'b0) begin miscompares++; $display("FAIL tvr_kept: got owner %b evt %b want 10 0", owner, lock_to_evt); end
    drive1(1'b1, 14'h009F, 16'h0000, 2'b00);
    tick;
    idle_all;
    #1;
    vectors++; if (owner !== 2'b00 || lock_to_evt !== 1'b0) begin miscompares++; $display("FAIL tvr_release: got owner %b evt %b want 00 0", owner, lock_to_evt); end
    tick;
  endtask

  task automatic test_chained_mac;
    logic [13:0] seq [4];
    seq[0] = 14'h009A; seq[1] = 14'h009C; seq[2] = 14'h009A; seq[3] = 14'h009C;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, seq[i], 16'h0100 + 16'(i), 2'b11);
      tick;
      vectors++; if (owner !== 2'b01) begin miscompares++; $display("FAIL mac_owner_w%0d: got %b want 01", i, owner); end
    end
    drive0(1'b1, 14'h009D, 16'h0000, 2'b00);
    tick;
    vectors++; if (owner !== 2'b01) begin miscompares++; $display("FAIL mac_reslo_keeps: got %b want 01", owner); end
    drive0(1'b1, 14'h009F, 16'h0000, 2'b00);
    mpy_per_dout = 16'h0001;
    #1;
    vectors++; if (r0_per_dout !== 16'h0001) begin miscompares++; $display("FAIL mac_sumext_dout: got %h want 0001", r0_per_dout); end
    tick;
    idle_all;
    #1;
    vectors++; if (owner !== 2'b00) begin miscompares++; $display("FAIL mac_release: got %b want 00", owner); end
    tick;
  endtask

  task automatic test_reset_mid_lock;
    drive1(1'b1, 14'h0098, 16'h0007, 2'b11);
    tick;
    drive1(1'b0, 14'h0, 16'h0, 2'b00);
    #1;
    vectors++; if (owner !== 2'b10) begin miscompares++; $display("FAIL rml_locked: got %b want 10", owner); end
    puc_rst = 1'b1;
    drive0(1'b1, 14'h009D, 16'h0000, 2'b00);
    #1;
    vectors++; if (mpy_per_en !== 1'b0 || r0_wait !== 1'b1) begin miscompares++; $display("FAIL rml_in_reset: got en %b wait %b want 0 1", mpy_per_en, r0_wait); end
    tick;
    puc_rst = 1'b0;
    #1;
    vectors++; if (owner !== 2'b00 || lock_to_evt !== 1'b0) begin miscompares++; $display("FAIL rml_dropped: got owner %b evt %b want 00 0", owner, lock_to_evt); end
    vectors++; if (r0_wait !== 1'b0 || mpy_per_en !== 1'b1) begin miscompares++; $display("FAIL rml_r0_grant: got wait %b en %b want 0 1", r0_wait, mpy_per_en); end
    tick;
    idle_all;
    #1;
    vectors++; if (lock_to_evt !== 1'b0) begin miscompares++; $display("FAIL rml_no_evt: got %b want 0", lock_to_evt); end
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    puc_rst      = 1'b1;
    mpy_per_dout = 16'h0000;
    idle_all;
    repeat (2) tick;
    test_reset;
    test_simultaneous;
    test_unlocked_read;
    test_lock_release;
    test_timeout;
    test_timeout_vs_request;
    test_chained_mac;
    test_reset_mid_lock;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
